axi_stream_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream AXI-style valid/ready channel, typically a buffering slice feeding a single master port, between NUM_REQ upstream requesters. Bursts are indivisible: once a requester is presented downstream, the grant is locked until that requester's `last` beat is accepted. Fairness rotates per completed burst, not per beat. The arbiter adds no buffering unless the optional output register is compiled in.

---
 rtl/axi_arb_pkg.sv | 18 +
 rtl/rr_prio_pick.sv | 32 +++
 rtl/axi_stream_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_axi_stream_rr_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI-stream round-robin arbiter: FSM state encoding and
// the index-width helper used to size requester indices.
package axi_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   function automatic int rr_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int RR_DEFAULT_REQ = 4;

   typedef logic [rr_idx_w(RR_DEFAULT_REQ)-1:0] rr_idx_t;

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating priority pick: first set bit of req scanning from ptr upward,
// wrapping modulo NUM_REQ.
module rr_prio_pick
   import axi_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = rr_idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [IW-1:0]      win,
   output logic               found
);

   always_comb begin
      int k;
      logic [IW-1:0] kk;
      k     = 0;
      kk    = '0;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k  = (int'(ptr) + i) % NUM_REQ;
         kk = IW'(k);
         if (!found && req[kk]) begin
            found = 1'b1;
            win   = kk;
         end
      end
   end

endmodule

// File: rtl/axi_stream_rr_arbiter.sv
// Burst-locked round-robin arbiter sharing one valid/ready channel among NUM_REQ
// requesters. Optional output register slice: define AXI_RR_ARB_OUT_REG_EN.
module axi_stream_rr_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [DATA_WIDTH-1:0]         data_o,
   output logic                          last_o,
   output logic [$clog2(NUM_REQ)-1:0]    gnt_idx_o,
   output logic                          busy_o
);

   localparam int            IW       = $clog2(NUM_REQ);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

   arb_state_e            state;
   logic [IW-1:0]         ptr;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         gnt_q;
   logic [IW-1:0]         win;
   logic [IW-1:0]         sel_idx;
   logic                  found;
   logic                  arb_valid;
   logic                  arb_last;
   logic                  arb_ready;
   logic                  arb_hs;
   logic [DATA_WIDTH-1:0] arb_data;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      return (i == LAST_IDX) ? '0 : i + 1'b1;
   endfunction

   rr_prio_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req   (req_valid_i),
      .ptr   (ptr),
      .win   (win),
      .found (found)
   );

   // While locked only the owner is connected, even if it drops valid mid-burst.
   always_comb begin
      sel_idx     = (state == LOCKED) ? idx : win;
      arb_valid   = (state == LOCKED) ? req_valid_i[idx] : found;
      arb_data    = req_data_i[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
      arb_last    = req_last_i[sel_idx];
      arb_hs      = arb_valid && arb_ready;
      req_ready_o = '0;
      if ((state == LOCKED) || found) begin
         req_ready_o[sel_idx] = arb_ready;
      end
      gnt_idx_o = (state == LOCKED) ? idx : (found ? win : gnt_q);
      busy_o    = (state == LOCKED);
   end

   // A presented winner locks unless it completes a single-beat burst at once,
   // which keeps the presented beat stable through downstream stalls.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         ptr   <= '0;
         idx   <= '0;
         gnt_q <= '0;
      end else begin
         gnt_q <= gnt_idx_o;
         case (state)
            IDLE: begin
               if (found) begin
                  if (arb_hs && arb_last) begin
                     ptr <= next_idx(win);
                  end else begin
                     state <= LOCKED;
                     idx   <= win;
                  end
               end
            end
            LOCKED: begin
               if (arb_hs && arb_last) begin
                  state <= IDLE;
                  ptr   <= next_idx(idx);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AXI_RR_ARB_OUT_REG_EN
   logic [DATA_WIDTH:0] slot [2];
   logic                wr_sel;
   logic                rd_sel;
   logic [1:0]          count;
   logic                out_hs;

   assign arb_ready        = (count != 2'd2);
   assign valid_o          = (count != 2'd0);
   assign out_hs           = valid_o && ready_i;
   assign {last_o, data_o} = slot[rd_sel];

   // Two-entry FIFO so a push and a pop can share a cycle at full rate.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot[0] <= '0;
         slot[1] <= '0;
         wr_sel  <= 1'b0;
         rd_sel  <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (arb_hs) begin
            slot[wr_sel] <= {arb_last, arb_data};
            wr_sel       <= ~wr_sel;
         end
         if (out_hs) begin
            rd_sel <= ~rd_sel;
         end
         count <= count + {1'b0, arb_hs} - {1'b0, out_hs};
      end
   end
`else
   assign arb_ready = ready_i;
   assign valid_o   = arb_valid;
   assign data_o    = arb_data;
   assign last_o    = arb_last;
`endif

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Self-checking bench for axi_stream_rr_arbiter (default build, no output slice):
// directed scenarios plus randomized traffic against a burst-ownership model.
module tb_axi_stream_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int IW = 2;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [N-1:0]    req_valid_i;
   logic [N-1:0]    req_ready_o;
   logic [N*DW-1:0] req_data_i;
   logic [N-1:0]    req_last_i;
   logic            valid_o;
   logic            ready_i;
   logic [DW-1:0]   data_o;
   logic            last_o;
   logic [IW-1:0]   gnt_idx_o;
   logic            busy_o;

   int total = 0;
   int bad   = 0;

   // Reference model: which requester owns the channel mid-burst (-1 if none),
   // where the next fair scan starts, and the most recent grant.
   int m_owner    = -1;
   int m_start    = 0;
   int m_last_gnt = 0;

   axi_stream_rr_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_data_i  (req_data_i),
      .req_last_i  (req_last_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .data_o      (data_o),
      .last_o      (last_o),
      .gnt_idx_o   (gnt_idx_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [DW-1:0] word(input int r, input int beat);
      return {16'hD00D, 16'(r), 16'h0000, 16'(beat)};
   endfunction

   function automatic int model_sel();
      if (m_owner >= 0) return m_owner;
      for (int i = 0; i < N; i++) begin
         int k;
         k = (m_start + i) % N;
         if (req_valid_i[IW'(k)]) return k;
      end
      return -1;
   endfunction

   task automatic set_word(input int r, input int beat);
      req_data_i[r*DW +: DW] = word(r, beat);
   endtask

   task automatic tick();
      int  s;
      bit  pres;
      @(posedge clk_i);
      s = model_sel();
      if (rst_i) begin
         m_owner    = -1;
         m_start    = 0;
         m_last_gnt = 0;
      end else if (s >= 0) begin
         m_last_gnt = s;
         pres = (m_owner >= 0) ? req_valid_i[IW'(s)] : 1'b1;
         if (pres && ready_i && req_last_i[IW'(s)]) begin
            m_owner = -1;
            m_start = (s + 1) % N;
         end else begin
            m_owner = s;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_i       = 1'b1;
      req_valid_i = '0;
      req_last_i  = '0;
      ready_i     = 1'b0;
      tick();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      ready_i = 1'b1;
      @(negedge clk_i);
      total++;
      if (valid_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_valid got=%b exp=0", valid_o);
      end
      total++;
      if (req_ready_o !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL reset_ready got=%b exp=0000", req_ready_o);
      end
      total++;
      if (busy_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_busy got=%b exp=0", busy_o);
      end
      total++;
      if (gnt_idx_o !== 2'd0) begin
         bad++;
         $display("[TB] FAIL reset_gnt got=%0d exp=0", gnt_idx_o);
      end
      tick();
   endtask

   task automatic test_round_robin();
      int exp_seq [5] = '{0, 1, 2, 3, 0};
      do_reset();
      req_valid_i = 4'hF;
      req_last_i  = 4'hF;
      ready_i     = 1'b1;
      for (int r = 0; r < N; r++) set_word(r, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         total++;
         if (gnt_idx_o !== IW'(exp_seq[c])) begin
            bad++;
            $display("[TB] FAIL rr_gnt c=%0d got=%0d exp=%0d", c, gnt_idx_o, exp_seq[c]);
         end
         total++;
         if (req_ready_o !== (4'(1) << exp_seq[c])) begin
            bad++;
            $display("[TB] FAIL rr_ready c=%0d got=%b exp_idx=%0d", c, req_ready_o, exp_seq[c]);
         end
         total++;
         if (valid_o !== 1'b1 || data_o !== word(exp_seq[c], 0)) begin
            bad++;
            $display("[TB] FAIL rr_data c=%0d got=%b/%h exp=1/%h", c, valid_o, data_o, word(exp_seq[c], 0));
         end
         tick();
      end
   endtask

   task automatic test_burst_lock();
      int exp_r [5] = '{2, 2, 2, 3, 0};
      int exp_b [5] = '{0, 1, 2, 0, 0};
      bit exp_busy [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      do_reset();
      req_valid_i = 4'b0010;
      req_last_i  = 4'b0010;
      ready_i     = 1'b1;
      set_word(1, 0);
      tick();
      set_word(0, 0);
      set_word(3, 0);
      for (int c = 0; c < 5; c++) begin
         req_valid_i = (c < 3) ? 4'b1101 : 4'b1001;
         req_last_i  = (c == 2) ? 4'b1101 : 4'b1001;
         set_word(2, c);
         @(negedge clk_i);
         total++;
         if (gnt_idx_o !== IW'(exp_r[c])) begin
            bad++;
            $display("[TB] FAIL lock_gnt c=%0d got=%0d exp=%0d", c, gnt_idx_o, exp_r[c]);
         end
         total++;
         if (req_ready_o !== (4'(1) << exp_r[c]) || data_o !== word(exp_r[c], exp_b[c])) begin
            bad++;
            $display("[TB] FAIL lock_path c=%0d got=%b/%h exp_idx=%0d beat=%0d", c, req_ready_o, data_o, exp_r[c], exp_b[c]);
         end
         total++;
         if (busy_o !== exp_busy[c]) begin
            bad++;
            $display("[TB] FAIL lock_busy c=%0d got=%b exp=%b", c, busy_o, exp_busy[c]);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      do_reset();
      req_valid_i = 4'b0001;
      req_last_i  = 4'b0001;
      ready_i     = 1'b1;
      set_word(0, 0);
      tick();
      req_valid_i = 4'b0010;
      req_last_i  = 4'b0000;
      ready_i     = 1'b0;
      set_word(1, 0);
      for (int c = 0; c < 5; c++) begin
         if (c >= 1) req_valid_i = 4'b0011;
         @(negedge clk_i);
         total++;
         if (gnt_idx_o !== 2'd1 || valid_o !== 1'b1 || data_o !== word(1, 0)) begin
            bad++;
            $display("[TB] FAIL stall_hold c=%0d got gnt=%0d v=%b d=%h exp 1/1/%h", c, gnt_idx_o, valid_o, data_o, word(1, 0));
         end
         total++;
         if (busy_o !== (c != 0) || req_ready_o !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL stall_busy c=%0d got busy=%b rdy=%b exp %b/0000", c, busy_o, req_ready_o, (c != 0));
         end
         tick();
      end
      ready_i    = 1'b1;
      req_last_i = 4'b0010;
      @(negedge clk_i);
      total++;
      if (req_ready_o !== 4'b0010 || gnt_idx_o !== 2'd1) begin
         bad++;
         $display("[TB] FAIL stall_release got rdy=%b gnt=%0d exp 0010/1", req_ready_o, gnt_idx_o);
      end
      tick();
      req_valid_i = 4'b0001;
      req_last_i  = 4'b0001;
      @(negedge clk_i);
      total++;
      if (gnt_idx_o !== 2'd0 || busy_o !== 1'b0 || valid_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL stall_next got gnt=%0d busy=%b v=%b exp 0/0/1", gnt_idx_o, busy_o, valid_o);
      end
      tick();
   endtask

   task automatic test_valid_drop();
      do_reset();
      req_valid_i = 4'b0010;
      req_last_i  = 4'b0000;
      ready_i     = 1'b1;
      set_word(1, 0);
      @(negedge clk_i);
      total++;
      if (gnt_idx_o !== 2'd1 || valid_o !== 1'b1) begin
         bad++;
         $display("[TB] FAIL drop_start got gnt=%0d v=%b exp 1/1", gnt_idx_o, valid_o);
      end
      tick();
      req_valid_i = 4'b0001;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk_i);
         total++;
         if (valid_o !== 1'b0 || busy_o !== 1'b1 || gnt_idx_o !== 2'd1 || req_ready_o !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL drop_hold c=%0d got v=%b busy=%b gnt=%0d rdy=%b exp 0/1/1/0010", c, valid_o, busy_o, gnt_idx_o, req_ready_o);
         end
         tick();
      end
      req_valid_i = 4'b0011;
      req_last_i  = 4'b0010;
      set_word(1, 1);
      @(negedge clk_i);
      total++;
      if (valid_o !== 1'b1 || data_o !== word(1, 1) || last_o !== 1'b1 || req_ready_o !== 4'b0010) begin
         bad++;
         $display("[TB] FAIL drop_resume got v=%b d=%h l=%b rdy=%b exp 1/%h/1/0010", valid_o, data_o, last_o, req_ready_o, word(1, 1));
      end
      tick();
      req_valid_i = 4'b0001;
      req_last_i  = 4'b0001;
      @(negedge clk_i);
      total++;
      if (gnt_idx_o !== 2'd0 || busy_o !== 1'b0) begin
         bad++;
         $display("[TB] FAIL drop_after got gnt=%0d busy=%b exp 0/0", gnt_idx_o, busy_o);
      end
      tick();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req_valid_i = 4'b1000;
      req_last_i  = 4'b0000;
      ready_i     = 1'b1;
      set_word(3, 0);
      tick();
      set_word(3, 1);
      rst_i = 1'b1;
      tick();
      rst_i       = 1'b0;
      req_valid_i = 4'b1010;
      set_word(1, 0);
      @(negedge clk_i);
      total++;
      if (busy_o !== 1'b0 || gnt_idx_o !== 2'd1) begin
         bad++;
         $display("[TB] FAIL midrst_state got busy=%b gnt=%0d exp 0/1", busy_o, gnt_idx_o);
      end
      total++;
      if (valid_o !== 1'b1 || req_ready_o !== 4'b0010 || data_o !== word(1, 0)) begin
         bad++;
         $display("[TB] FAIL midrst_path got v=%b rdy=%b d=%h exp 1/0010/%h", valid_o, req_ready_o, data_o, word(1, 0));
      end
      tick();
   endtask

   task automatic test_random();
      int           s;
      logic         ev;
      logic [N-1:0] er;
      logic [IW-1:0] eg;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst_i       = ($urandom_range(0, 63) == 0);
         req_valid_i = N'($urandom);
         req_last_i  = N'($urandom);
         ready_i     = ($urandom_range(0, 3) != 0);
         for (int r = 0; r < N; r++) req_data_i[r*DW +: DW] = {$urandom, $urandom};
         @(negedge clk_i);
         s  = model_sel();
         ev = (m_owner >= 0) ? req_valid_i[IW'(m_owner)] : (s >= 0);
         er = (s >= 0 && ready_i) ? (4'(1) << s) : 4'b0000;
         eg = (s >= 0) ? IW'(s) : IW'(m_last_gnt);
         total++;
         if (valid_o !== ev || req_ready_o !== er) begin
            bad++;
            $display("[TB] FAIL rand_hs c=%0d got v=%b rdy=%b exp v=%b rdy=%b", c, valid_o, req_ready_o, ev, er);
         end
         total++;
         if (gnt_idx_o !== eg || busy_o !== (m_owner >= 0)) begin
            bad++;
            $display("[TB] FAIL rand_gnt c=%0d got gnt=%0d busy=%b exp gnt=%0d busy=%b", c, gnt_idx_o, busy_o, eg, (m_owner >= 0));
         end
         if (ev) begin
            total++;
            if (data_o !== req_data_i[s*DW +: DW] || last_o !== req_last_i[IW'(s)]) begin
               bad++;
               $display("[TB] FAIL rand_data c=%0d got %h/%b exp %h/%b", c, data_o, last_o, req_data_i[s*DW +: DW], req_last_i[IW'(s)]);
            end
         end
         tick();
      end
   endtask

   initial begin
      rst_i       = 1'b1;
      req_valid_i = '0;
      req_last_i  = '0;
      req_data_i  = '0;
      ready_i     = 1'b0;
      test_reset();
      test_round_robin();
      test_burst_lock();
      test_stall();
      test_valid_drop();
      test_reset_mid_burst();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
